// File: rtl/alu_ctrl_issue.sv
// alu_ctrl_issue
// ---------------------------------------------------------------------------
// ALU-control issue stage sitting between instruction decode and the 64-bit
// datapath ALU. An ALUOp/funct3/funct7[5] bundle plus two operands is taken in
// over a valid/ready handshake, the 4-bit ALU control code is decoded on the
// input side, and control plus operands are presented to the ALU from a
// registered main register. A skid register absorbs one extra bundle so that
// in_ready can stay a pure flop output with no path from out_ready.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   in_valid / in_ready      upstream handshake (in_ready registered)
//   in_alu_op                00 ld/st, 01 branch, 10 R-type, 11 reserved
//   in_funct3, in_funct7_b5  instruction function fields
//   in_op1, in_op2           operands (DATA_W bits)
//   out_valid / out_ready    downstream handshake (out_valid registered)
//   out_alu_ctrl             0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 illegal
//   out_input1, out_input2   operands aligned with out_alu_ctrl
//   out_illegal              bundle decoded as illegal
//   err_sticky               sticky illegal-issued flag
//
// Optional feature macro: ALU_CTRL_ISSUE_ERR_STICKY_EN
//   defined   -> err_sticky sets when an illegal bundle transfers out and
//                holds until rst
//   undefined -> err_sticky is tied to 0
// ---------------------------------------------------------------------------
module alu_ctrl_issue #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_alu_op,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7_b5,
  input  logic [DATA_W-1:0] in_op1,
  input  logic [DATA_W-1:0] in_op2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_alu_ctrl,
  output logic [DATA_W-1:0] out_input1,
  output logic [DATA_W-1:0] out_input2,
  output logic              out_illegal,
  output logic              err_sticky
);

  localparam logic [3:0] CTRL_AND = 4'b0000;
  localparam logic [3:0] CTRL_OR  = 4'b0001;
  localparam logic [3:0] CTRL_ADD = 4'b0010;
  localparam logic [3:0] CTRL_SUB = 4'b0110;
  localparam logic [3:0] CTRL_ILL = 4'b1111;

  // Occupancy of the two storage registers.
  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_TWO   = 2'b10
  } state_t;

  state_t            state;
  logic [3:0]        dec_ctrl;
  logic              dec_illegal;
  logic [3:0]        skid_ctrl;
  logic              skid_illegal;
  logic [DATA_W-1:0] skid_op1;
  logic [DATA_W-1:0] skid_op2;
  logic              in_xfer;
  logic              out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Decode the incoming bundle before it is registered. funct7[5] only
  // matters for funct3=000, where it selects SUB over ADD. Anything not
  // recognised is tagged illegal but still flows through in order.
  always_comb begin
    dec_ctrl    = CTRL_ILL;
    dec_illegal = 1'b1;
    unique case (in_alu_op)
      2'b00: begin
        dec_ctrl    = CTRL_ADD;
        dec_illegal = 1'b0;
      end
      2'b01: begin
        dec_ctrl    = CTRL_SUB;
        dec_illegal = 1'b0;
      end
      2'b10: begin
        case (in_funct3)
          3'b000: begin
            dec_ctrl    = in_funct7_b5 ? CTRL_SUB : CTRL_ADD;
            dec_illegal = 1'b0;
          end
          3'b111: begin
            dec_ctrl    = CTRL_AND;
            dec_illegal = 1'b0;
          end
          3'b110: begin
            dec_ctrl    = CTRL_OR;
            dec_illegal = 1'b0;
          end
          default: begin
            dec_ctrl    = CTRL_ILL;
            dec_illegal = 1'b1;
          end
        endcase
      end
      default: begin
        dec_ctrl    = CTRL_ILL;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Skid-buffer controller. Both handshake outputs are computed for the next
  // state and registered here, so in_ready never depends on out_ready in the
  // same cycle. In TWO in_ready is already low, so no input transfer can
  // arrive there; the skid entry moves into main as soon as main drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_EMPTY;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      out_alu_ctrl <= '0;
      out_input1   <= '0;
      out_input2   <= '0;
      out_illegal  <= 1'b0;
      skid_ctrl    <= '0;
      skid_illegal <= 1'b0;
      skid_op1     <= '0;
      skid_op2     <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (in_xfer) begin
            out_alu_ctrl <= dec_ctrl;
            out_illegal  <= dec_illegal;
            out_input1   <= in_op1;
            out_input2   <= in_op2;
            out_valid    <= 1'b1;
            state        <= S_ONE;
          end
        end
        S_ONE: begin
          if (in_xfer && out_xfer) begin
            out_alu_ctrl <= dec_ctrl;
            out_illegal  <= dec_illegal;
            out_input1   <= in_op1;
            out_input2   <= in_op2;
          end else if (out_xfer) begin
            out_valid <= 1'b0;
            state     <= S_EMPTY;
          end else if (in_xfer) begin
            skid_ctrl    <= dec_ctrl;
            skid_illegal <= dec_illegal;
            skid_op1     <= in_op1;
            skid_op2     <= in_op2;
            in_ready     <= 1'b0;
            state        <= S_TWO;
          end
        end
        S_TWO: begin
          if (out_xfer) begin
            out_alu_ctrl <= skid_ctrl;
            out_illegal  <= skid_illegal;
            out_input1   <= skid_op1;
            out_input2   <= skid_op2;
            in_ready     <= 1'b1;
            state        <= S_ONE;
          end
        end
        default: begin
          state     <= S_EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef ALU_CTRL_ISSUE_ERR_STICKY_EN
  // Latch the first illegal bundle handed to the ALU; only rst clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sticky <= 1'b0;
    end else if (out_xfer && out_illegal) begin
      err_sticky <= 1'b1;
    end
  end
`else
  assign err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// tb_alu_ctrl_issue
// ---------------------------------------------------------------------------
// Scoreboard bench for alu_ctrl_issue. The driver pushes the expected
// decoded bundle whenever an input transfer is about to happen; an
// independent monitor compares the queue head with the DUT outputs on every
// falling edge where out_valid is high and pops it when out_ready is high.
// ---------------------------------------------------------------------------
module tb_alu_ctrl_issue;

  localparam int DATA_W = 64;

  typedef struct packed {
    logic              ill;
    logic [3:0]        ctrl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } exp_t;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_alu_op;
  logic [2:0]        in_funct3;
  logic              in_funct7_b5;
  logic [DATA_W-1:0] in_op1;
  logic [DATA_W-1:0] in_op2;
  logic              out_valid;
  logic              out_ready;
  logic [3:0]        out_alu_ctrl;
  logic [DATA_W-1:0] out_input1;
  logic [DATA_W-1:0] out_input2;
  logic              out_illegal;
  logic              err_sticky;

  logic dirReady;
  logic rndReady;
  logic randOn;
  logic monOn;
  logic errExp;
  exp_t sb[$];
  exp_t monHead;
  int   compared;
  int   mismatched;

  assign out_ready = randOn ? rndReady : dirReady;

  alu_ctrl_issue #(.DATA_W(DATA_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_alu_op    (in_alu_op),
    .in_funct3    (in_funct3),
    .in_funct7_b5 (in_funct7_b5),
    .in_op1       (in_op1),
    .in_op2       (in_op2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_alu_ctrl (out_alu_ctrl),
    .out_input1   (out_input1),
    .out_input2   (out_input2),
    .out_illegal  (out_illegal),
    .err_sticky   (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Random downstream backpressure, updated just after each rising edge.
  always @(posedge clk) begin
    if (randOn) begin
      #1;
      rndReady = 1'($urandom_range(0, 1));
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference decode written as a priority list of the legal encodings.
  function automatic logic [4:0] modelDecode(input logic [1:0] op,
                                             input logic [2:0] f3,
                                             input logic b5);
    if (op == 2'b00) return 5'b0_0010;
    if (op == 2'b01) return 5'b0_0110;
    if (op == 2'b10 && f3 == 3'b000) return b5 ? 5'b0_0110 : 5'b0_0010;
    if (op == 2'b10 && f3 == 3'b111) return 5'b0_0000;
    if (op == 2'b10 && f3 == 3'b110) return 5'b0_0001;
    return 5'b1_1111;
  endfunction

  task automatic randomJunk();
    in_alu_op    = 2'($urandom_range(0, 3));
    in_funct3    = 3'($urandom_range(0, 7));
    in_funct7_b5 = 1'($urandom_range(0, 1));
    in_op1       = {$urandom(), $urandom()};
    in_op2       = {$urandom(), $urandom()};
  endtask

  // Called just after a rising edge. Holds the bundle until it is accepted,
  // records the expectation on the falling edge before the accepting edge,
  // and returns just after that edge.
  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3,
                               input logic b5, input logic [63:0] a,
                               input logic [63:0] b, input logic [3:0] expCtrl,
                               input logic expIll);
    exp_t e;
    bit   done;
    done         = 1'b0;
    in_alu_op    = op;
    in_funct3    = f3;
    in_funct7_b5 = b5;
    in_op1       = a;
    in_op2       = b;
    in_valid     = 1'b1;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        e.ill  = expIll;
        e.ctrl = expCtrl;
        e.a    = a;
        e.b    = b;
        sb.push_back(e);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
    in_valid = 1'b0;
    randomJunk();
  endtask

  task automatic applyModel(input logic [1:0] op, input logic [2:0] f3,
                            input logic b5);
    logic [4:0] r;
    r = modelDecode(op, f3, b5);
    applyStimulus(op, f3, b5, {$urandom(), $urandom()},
                  {$urandom(), $urandom()}, r[3:0], r[4]);
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
    if (sb.size() != 0) checkOutput("drain_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    checkOutput({tag, "_alu_ctrl"}, 64'(out_alu_ctrl), 64'd0);
    checkOutput({tag, "_input1"}, out_input1, 64'd0);
    checkOutput({tag, "_illegal"}, 64'(out_illegal), 64'd0);
    checkOutput({tag, "_err_sticky"}, 64'(err_sticky), 64'd0);
  endtask

  // Scoreboard monitor: every falling edge with out_valid compares the DUT
  // against the queue head, which also proves outputs hold while stalled.
  always @(negedge clk) begin
    if (!rst && monOn) begin
      checkOutput("err_sticky", 64'(err_sticky), 64'(errExp));
      if (out_valid) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 64'(out_valid), 64'd0);
        end else begin
          monHead = sb[0];
          checkOutput("alu_ctrl", 64'(out_alu_ctrl), 64'(monHead.ctrl));
          checkOutput("illegal", 64'(out_illegal), 64'(monHead.ill));
          checkOutput("input1", out_input1, monHead.a);
          checkOutput("input2", out_input2, monHead.b);
          if (out_ready) begin
`ifdef ALU_CTRL_ISSUE_ERR_STICKY_EN
            errExp = errExp | monHead.ill;
`endif
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    logic [2:0] legalF3 [3];
    logic [1:0] sop;
    logic [2:0] sf3;
    logic       sb5;
    logic [4:0] r;
    exp_t       e;
    legalF3[0] = 3'b000;
    legalF3[1] = 3'b111;
    legalF3[2] = 3'b110;

    compared   = 0;
    mismatched = 0;
    monOn      = 1'b0;
    randOn     = 1'b0;
    rndReady   = 1'b0;
    dirReady   = 1'b0;
    errExp     = 1'b0;
    rst        = 1'b0;
    in_valid   = 1'b0;
    randomJunk();

    // Power-on reset, checked while still asserted.
    #2 rst = 1'b1;
    #1 checkResetState("por");
    @(posedge clk);
    #1 rst = 1'b0;
    monOn = 1'b1;

    // Directed decode sweep with hand-computed codes; each bundle must show
    // up right after its accepting edge.
    $display("[TB] decode sweep");
    dirReady = 1'b1;
    applyStimulus(2'b10, 3'b000, 1'b1, 64'd10, 64'd4, 4'b0110, 1'b0);
    checkOutput("latency_sub", 64'(out_valid), 64'd1);
    applyStimulus(2'b10, 3'b000, 1'b0, 64'd11, 64'd5, 4'b0010, 1'b0);
    checkOutput("latency_add", 64'(out_valid), 64'd1);
    applyStimulus(2'b10, 3'b111, 1'b0, 64'hFF00, 64'h0FF0, 4'b0000, 1'b0);
    checkOutput("latency_and", 64'(out_valid), 64'd1);
    applyStimulus(2'b10, 3'b110, 1'b0, 64'h1, 64'h2, 4'b0001, 1'b0);
    applyStimulus(2'b10, 3'b111, 1'b1, 64'h3, 64'h4, 4'b0000, 1'b0);
    applyStimulus(2'b00, 3'b101, 1'b1, 64'h5, 64'h6, 4'b0010, 1'b0);
    applyStimulus(2'b01, 3'b011, 1'b0, 64'h7, 64'h8, 4'b0110, 1'b0);
    applyStimulus(2'b10, 3'b001, 1'b0, 64'h9, 64'hA, 4'b1111, 1'b1);
    checkOutput("latency_illegal", 64'(out_illegal), 64'd1);
    applyStimulus(2'b11, 3'b000, 1'b0, 64'hB, 64'hC, 4'b1111, 1'b1);
    waitDrain();

    // Backpressure: A and B fill the stage, C must be held off.
    $display("[TB] backpressure");
    dirReady = 1'b0;
    applyStimulus(2'b00, 3'b000, 1'b0, 64'd5, 64'd3, 4'b0010, 1'b0);
    applyStimulus(2'b10, 3'b000, 1'b1, 64'd100, 64'd40, 4'b0110, 1'b0);
    checkOutput("bp_in_ready_after_b", 64'(in_ready), 64'd0);
    in_alu_op    = 2'b10;
    in_funct3    = 3'b110;
    in_funct7_b5 = 1'b0;
    in_op1       = 64'hC0DE;
    in_op2       = 64'hBEEF;
    in_valid     = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_c_held", 64'(in_ready), 64'd0);
    end
    @(posedge clk);
    #1 dirReady = 1'b1;
    applyStimulus(2'b10, 3'b110, 1'b0, 64'hC0DE, 64'hBEEF, 4'b0001, 1'b0);
    waitDrain();

    // Asynchronous reset while the stage holds two bundles.
    $display("[TB] reset in TWO");
    dirReady = 1'b0;
    applyModel(2'b00, 3'b000, 1'b0);
    applyModel(2'b10, 3'b111, 1'b0);
    checkOutput("pre_reset_in_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1 checkResetState("mid");
    sb.delete();
    errExp = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;

    // Full-rate streaming of legal bundles.
    $display("[TB] streaming");
    dirReady = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sop = 2'($urandom_range(0, 2));
      sf3 = legalF3[$urandom_range(0, 2)];
      sb5 = 1'($urandom_range(0, 1));
      r   = modelDecode(sop, sf3, sb5);
      in_alu_op    = sop;
      in_funct3    = sf3;
      in_funct7_b5 = sb5;
      in_op1       = {$urandom(), $urandom()};
      in_op2       = {$urandom(), $urandom()};
      in_valid     = 1'b1;
      @(negedge clk);
      checkOutput("stream_in_ready", 64'(in_ready), 64'd1);
      if (in_ready) begin
        e.ill  = r[4];
        e.ctrl = r[3:0];
        e.a    = in_op1;
        e.b    = in_op2;
        sb.push_back(e);
      end
      if (i > 0) checkOutput("stream_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    waitDrain();

    // Random valid/ready traffic, including illegal encodings.
    $display("[TB] random traffic");
    randOn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      applyModel(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1 randomJunk();
      end
    end
    randOn = 1'b0;
    @(posedge clk);
    #2 dirReady = 1'b1;
    waitDrain();

    // Sticky error flag around an illegal issue.
    $display("[TB] sticky error");
    #2 rst = 1'b1;
    errExp = 1'b0;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(2'b00, 3'b000, 1'b0, 64'd1, 64'd2, 4'b0010, 1'b0);
    waitDrain();
    checkOutput("sticky_before", 64'(err_sticky), 64'd0);
    applyStimulus(2'b11, 3'b000, 1'b0, 64'd3, 64'd4, 4'b1111, 1'b1);
    applyStimulus(2'b00, 3'b000, 1'b0, 64'd5, 64'd6, 4'b0010, 1'b0);
    applyStimulus(2'b10, 3'b000, 1'b0, 64'd7, 64'd8, 4'b0010, 1'b0);
    waitDrain();
    repeat (3) @(posedge clk);
    #1;
`ifdef ALU_CTRL_ISSUE_ERR_STICKY_EN
    checkOutput("sticky_after", 64'(err_sticky), 64'd1);
`else
    checkOutput("sticky_after", 64'(err_sticky), 64'd0);
`endif
    #2 rst = 1'b1;
    errExp = 1'b0;
    #1 checkOutput("sticky_cleared", 64'(err_sticky), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_issue.md
# alu_ctrl_issue

Pipelined ALU-control issue stage between instruction decode and the 64-bit datapath ALU. It accepts an ALUOp/funct3/funct7 bundle and two 64-bit operands over a valid/ready handshake, decodes the 4-bit ALU control signal, and presents control and operands to the ALU on a registered valid/ready output. A two-entry skid buffer keeps every handshake signal registered. Stalls propagate back to decode without dropping or duplicating operations.

## Interface
- DATA_W, 64, operand width; matches ALU input1/input2.
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  upstream bundle valid.
- in_ready  output  1  stage can accept; registered.
- in_alu_op  input  2  00 load/store, 01 branch, 10 R-type, 11 reserved.
- in_funct3  input  3  instruction funct3.
- in_funct7_b5  input  1  instruction funct7 bit 5.
- in_op1, in_op2  input  DATA_W  operands.
- out_valid  output  1  issued bundle valid; registered.
- out_ready  input  1  ALU/downstream accepts.
- out_alu_ctrl  output  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1111 illegal.
- out_input1, out_input2  output  DATA_W  operands aligned with out_alu_ctrl.
- out_illegal  output  1  bundle decoded illegal.
- err_sticky  output  1  sticky illegal flag (see Configuration).

## Operation
- Decode (combinational, on input side):
  - alu_op 00 gives 0010.
  - alu_op 01 gives 0110.
  - alu_op 10 with funct3 000/b5=0 gives 0010; 000/b5=1 gives 0110; 111 gives 0000; 110 gives 0001.
  - Any other funct3 under 10, and all of alu_op 11, gives 1111 with illegal=1.
  - funct7_b5 is ignored except for funct3=000.
- Illegal bundles still flow through in order. The ALU default yields result 0.
- Transfers occur on a cycle where valid&&ready is true on that side.
- Storage:
  - Main register: drives the out_* signals.
  - Skid register: captures a bundle accepted while the main register is full and out_ready=0.
- States (skid occupancy):
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: main full, in_ready=1.
  - TWO: main and skid full, in_ready=0.
- Transitions:
  - EMPTY→ONE on input transfer.
  - ONE→ONE on simultaneous in/out transfer; main reloads with the new bundle.
  - ONE→EMPTY on output transfer only.
  - ONE→TWO on input transfer with out_ready=0.
  - TWO→ONE on output transfer; skid moves to main.
- Ordering is strictly FIFO. No bundle is lost or duplicated.
- Outputs hold stable while out_valid=1 and out_ready=0.
- Reset, including mid-operation, gives the following on the next evaluation:
  - State EMPTY; out_valid=0, in_ready=1.
  - out_alu_ctrl=0000, out_input1/2=0, out_illegal=0, err_sticky=0.
  - Buffered bundles are discarded.

## Timing
- Latency: input transfer at edge N gives out_valid=1 after edge N, when the main register is empty or draining that cycle.
- Throughput: one bundle per cycle with out_ready held high.
- in_ready is a register output with no combinational path from out_ready. in_ready deasserts the cycle after TWO is entered.
- Inputs are sampled only when in_valid&&in_ready. Input values are don't-care otherwise.
- out_* data has no combinational path from any input port.

## Configuration
- Macro: ALU_CTRL_ISSUE_ERR_STICKY_EN.
- Defined:
  - err_sticky goes to 1 on the edge where an illegal bundle transfers out (out_valid&&out_ready&&out_illegal).
  - It stays 1 until rst.
- Undefined:
  - err_sticky is tied to 0 and no flop is inferred.
  - out_illegal behaves the same either way.

## Test plan
- Reset: assert rst mid-stream with the stage in TWO → out_valid=0, in_ready=1, out_alu_ctrl=0000, err_sticky=0 immediately, asynchronously.
- Decode sweep, out_ready=1:
  - (10,000,b5=1) gives 0110; (10,111) gives 0000; (10,110) gives 0001; (00,xxx) gives 0010; (01,xxx) gives 0110.
  - (10,001) and (11,000) give 1111 with out_illegal=1.
  - Each appears one cycle after transfer.
- Backpressure:
  - Send A(op1=5,op2=3), B, C with out_ready=0.
  - A and B are accepted; in_ready=0 from the cycle after B; C is held.
  - Then raise out_ready → A, B, C issue in order with operands intact.
- Streaming: 100 random legal bundles, out_ready=1, in_valid=1 → one output per cycle and in_ready never drops.
- Random valid/ready toggling for 10k cycles → scoreboard shows an exact in-order match and out_* stable while stalled.
- Sticky error, macro defined: issue (11,000) then legal ADDs → err_sticky=1 from the illegal transfer until rst. Macro undefined: err_sticky stays 0.
